// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the fetch/PC unit
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    J   = 2'd2,
    JR  = 2'd3
  } redir_sel_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - priority selection of the redirect source and target
module next_pc_sel
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic [ADDR_W-1:0] pc_plus4_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] target_o
);

  // Low 28 bits come from the instruction index, the rest from pc+4.
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  logic [ADDR_W-1:0] w_jump_target;
  redir_sel_t        w_sel;

  assign w_jump_target = (pc_plus4_i & ~LOW28_MASK) | ADDR_W'({jump_index_i, 2'b00});

  // Branch beats jump beats jump-register.
  always_comb begin
    w_sel    = SEQ;
    target_o = pc_plus4_i;
    if (branch_taken_i) begin
      w_sel    = BR;
      target_o = branch_target_i;
    end else if (jump_i) begin
      w_sel    = J;
      target_o = w_jump_target;
    end else if (jr_i) begin
      w_sel    = JR;
      target_o = jr_target_i;
    end
  end

  assign redirect_o = (w_sel != SEQ);

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register and instruction-fetch FSM; PC_ALIGN_TRAP_EN enables the misaligned-redirect trap
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              fetch_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INSTR_BYTES);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_drain_tgt;
  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc;

  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] w_drain_tgt_nxt;
  logic              w_valid_nxt;
  logic              w_load;
  logic              w_req;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_raw_target;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + STEP;

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .pc_plus4_i      (w_pc_plus4),
    .redirect_o      (w_redirect),
    .target_o        (w_raw_target)
  );

`ifdef PC_ALIGN_TRAP_EN
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VECTOR);

  logic w_misaligned;
  logic w_take_redirect;
  logic r_misalign;

  assign w_misaligned    = |w_raw_target[1:0];
  assign w_target        = w_misaligned ? EXC_PC : w_raw_target;
  assign w_take_redirect = w_redirect && (r_state != BOOT);

  // One-cycle trap pulse for every redirect the FSM acts on with a bad target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_take_redirect && w_misaligned;
  end

  assign misalign_o = r_misalign;
`else
  assign w_target   = w_raw_target & ~ADDR_W'(3);
  assign misalign_o = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next state, request, and next values of the fetch datapath.
  always_comb begin
    w_state_nxt     = r_state;
    w_req           = 1'b0;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_drain_tgt_nxt = r_drain_tgt;
    w_valid_nxt     = r_valid;
    w_load          = 1'b0;
    // Decode takes the current instruction whenever it is not stalled.
    if (r_valid && !stall_i) w_valid_nxt = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        w_req = 1'b1;
        if (w_redirect) begin
          w_valid_nxt = 1'b0;
          if (imem_ack_i) begin
            w_fetch_pc_nxt = w_target;
          end else begin
            w_drain_tgt_nxt = w_target;
            w_state_nxt     = DRAIN;
          end
        end else if (imem_ack_i) begin
          w_load         = 1'b1;
          w_valid_nxt    = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + STEP;
          if (stall_i) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_valid_nxt    = 1'b0;
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = FETCH;
        end else if (!stall_i) begin
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        // The outstanding request must complete at its original address.
        w_req = 1'b1;
        if (imem_ack_i) begin
          w_fetch_pc_nxt = w_redirect ? w_target : r_drain_tgt;
          w_state_nxt    = FETCH;
        end else if (w_redirect) begin
          w_drain_tgt_nxt = w_target;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  // Fetch address, saved drain target and the decode-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RST_PC;
      r_drain_tgt <= RST_PC;
      r_valid     <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_pc        <= RST_PC;
    end else begin
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_drain_tgt <= w_drain_tgt_nxt;
      r_valid     <= w_valid_nxt;
      if (w_load) begin
        r_instr <= imem_rdata_i;
        r_pc    <= r_fetch_pc;
      end
    end
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign fetch_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pc_plus4;

endmodule
